// File: rtl/clock_reset_sequencer.sv
// PLL supervisor: timed pll_rst pulse, lock qualification, staggered domain reset release.
// Latency: pll_locked reaches the FSM after 2 sync stages; all outputs are registered.
// Backpressure: none. CLKSEQ_PLL_RETRY_EN makes a lock timeout retry the PLL instead of parking in FAILED.
module clock_reset_sequencer #(
  parameter int NUM_DOMAINS        = 3,
  parameter int PLL_RST_CYCLES     = 32,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_DELAY        = 16,
  parameter int LOCK_TIMEOUT       = 65536
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pll_locked,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   all_ready,
  output logic [2:0]             seq_state,
  output logic [15:0]            lock_loss_count,
  output logic                   lock_fail
);

  localparam int RST_W  = $clog2(PLL_RST_CYCLES) + 1;
  localparam int TO_W   = $clog2(LOCK_TIMEOUT) + 1;
  localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int DLY_W  = $clog2(STAGE_DELAY) + 1;
  localparam int IDX_W  = $clog2(NUM_DOMAINS) + 1;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RELEASE   = 3'd3,
    RUNNING   = 3'd4,
    FAILED    = 3'd5
  } state_t;

  state_t                 state, state_nxt;
  logic                   lock_meta, locked_sync;
  logic [RST_W-1:0]       rst_cnt, rst_cnt_nxt;
  logic [TO_W-1:0]        wait_cnt, wait_cnt_nxt;
  logic [STAB_W-1:0]      stab_cnt, stab_cnt_nxt;
  logic [DLY_W-1:0]       stage_cnt, stage_cnt_nxt;
  logic [IDX_W-1:0]       stage, stage_nxt;
  logic                   pll_rst_nxt, all_ready_nxt, lock_fail_nxt;
  logic [NUM_DOMAINS-1:0] domain_rst_nxt;
  logic [15:0]            lock_loss_count_nxt;

  assign seq_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta       <= 1'b0;
      locked_sync     <= 1'b0;
      state           <= RESET_PLL;
      rst_cnt         <= '0;
      wait_cnt        <= '0;
      stab_cnt        <= '0;
      stage_cnt       <= '0;
      stage           <= '0;
      pll_rst         <= 1'b1;
      domain_rst      <= '1;
      all_ready       <= 1'b0;
      lock_loss_count <= '0;
      lock_fail       <= 1'b0;
    end else begin
      lock_meta       <= pll_locked;
      locked_sync     <= lock_meta;
      state           <= state_nxt;
      rst_cnt         <= rst_cnt_nxt;
      wait_cnt        <= wait_cnt_nxt;
      stab_cnt        <= stab_cnt_nxt;
      stage_cnt       <= stage_cnt_nxt;
      stage           <= stage_nxt;
      pll_rst         <= pll_rst_nxt;
      domain_rst      <= domain_rst_nxt;
      all_ready       <= all_ready_nxt;
      lock_loss_count <= lock_loss_count_nxt;
      lock_fail       <= lock_fail_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    rst_cnt_nxt         = rst_cnt;
    wait_cnt_nxt        = wait_cnt;
    stab_cnt_nxt        = stab_cnt;
    stage_cnt_nxt       = stage_cnt;
    stage_nxt           = stage;
    pll_rst_nxt         = pll_rst;
    domain_rst_nxt      = domain_rst;
    all_ready_nxt       = all_ready;
    lock_loss_count_nxt = lock_loss_count;
    lock_fail_nxt       = lock_fail;

    case (state)
      RESET_PLL: begin
        if (rst_cnt == RST_W'(PLL_RST_CYCLES - 1)) begin
          state_nxt   = WAIT_LOCK;
          rst_cnt_nxt = '0;
          pll_rst_nxt = 1'b0;
        end else begin
          rst_cnt_nxt = rst_cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        // Lock seen on the timeout cycle takes priority over the timeout.
        if (locked_sync) begin
          state_nxt    = STABILIZE;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
          wait_cnt_nxt  = '0;
          lock_fail_nxt = 1'b1;
          pll_rst_nxt   = 1'b1;
`ifdef CLKSEQ_PLL_RETRY_EN
          state_nxt     = RESET_PLL;
`else
          state_nxt     = FAILED;
`endif
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      STABILIZE: begin
        if (!locked_sync) begin
          state_nxt    = WAIT_LOCK;
          stab_cnt_nxt = '0;
        end else if (stab_cnt == STAB_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_nxt         = RELEASE;
          stab_cnt_nxt      = '0;
          stage_nxt         = '0;
          stage_cnt_nxt     = '0;
          domain_rst_nxt[0] = 1'b0;
        end else begin
          stab_cnt_nxt = stab_cnt + 1'b1;
        end
      end
      RELEASE, RUNNING: begin
        if (!locked_sync) begin
          state_nxt      = RESET_PLL;
          pll_rst_nxt    = 1'b1;
          domain_rst_nxt = '1;
          all_ready_nxt  = 1'b0;
          stage_nxt      = '0;
          stage_cnt_nxt  = '0;
          if (lock_loss_count != 16'hFFFF) lock_loss_count_nxt = lock_loss_count + 16'd1;
        end else if (state == RELEASE) begin
          if (stage == IDX_W'(NUM_DOMAINS - 1)) begin
            state_nxt     = RUNNING;
            all_ready_nxt = 1'b1;
            stage_nxt     = '0;
            stage_cnt_nxt = '0;
          end else if (stage_cnt == DLY_W'(STAGE_DELAY - 1)) begin
            stage_nxt     = stage + 1'b1;
            stage_cnt_nxt = '0;
            for (int i = 0; i < NUM_DOMAINS; i++) begin
              if (i == int'(stage) + 1) domain_rst_nxt[i] = 1'b0;
            end
          end else begin
            stage_cnt_nxt = stage_cnt + 1'b1;
          end
        end
      end
      FAILED: begin
        pll_rst_nxt    = 1'b1;
        domain_rst_nxt = '1;
        all_ready_nxt  = 1'b0;
      end
      default: state_nxt = RESET_PLL;
    endcase
  end

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Directed table-driven bench for clock_reset_sequencer (3 domains, short timings).
module tb_clock_reset_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pll_locked;
  logic        pll_rst;
  logic [2:0]  domain_rst;
  logic        all_ready;
  logic [2:0]  seq_state;
  logic [15:0] lock_loss_count;
  logic        lock_fail;

  int n_cmp = 0;
  int n_bad = 0;

  clock_reset_sequencer #(
    .NUM_DOMAINS(3), .PLL_RST_CYCLES(4), .LOCK_STABLE_CYCLES(8),
    .STAGE_DELAY(2), .LOCK_TIMEOUT(32)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .domain_rst(domain_rst), .all_ready(all_ready), .seq_state(seq_state),
    .lock_loss_count(lock_loss_count), .lock_fail(lock_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic        rst;
    logic        lk;
    logic        pll;
    logic [2:0]  dom;
    logic        rdy;
    logic [2:0]  st;
    logic [15:0] llc;
    logic        fail;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic r, input logic lk, input logic pll,
                     input logic [2:0] dom, input logic rdy, input logic [2:0] st,
                     input logic [15:0] llc, input logic fail);
    vec_t v;
    v.n = n; v.rst = r; v.lk = lk; v.pll = pll; v.dom = dom;
    v.rdy = rdy; v.st = st; v.llc = llc; v.fail = fail;
    vecs.push_back(v);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    rst        = v.rst;
    pll_locked = v.lk;
    repeat (v.n) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({pll_rst, domain_rst, all_ready, seq_state, lock_loss_count, lock_fail} !==
        {v.pll, v.dom, v.rdy, v.st, v.llc, v.fail}) begin
      n_bad++;
      $display("FAIL vec[%0d]: got pll_rst=%b dom=%b rdy=%b st=%0d llc=%0d fail=%b; want pll_rst=%b dom=%b rdy=%b st=%0d llc=%0d fail=%b",
               idx, pll_rst, domain_rst, all_ready, seq_state, lock_loss_count, lock_fail,
               v.pll, v.dom, v.rdy, v.st, v.llc, v.fail);
    end
  endtask

  initial begin
    int first_pll_low;
    int rel [3];
    int rdy_cyc;

    rst        = 1'b1;
    pll_locked = 1'b0;

    //    n  rst lk  pll dom    rdy st  llc fail
    add(3,  1, 0,  1, 3'b111, 0, 0, 0, 0);   // reset state
    // nominal bring-up, lock raised after edge 10
    add(3,  0, 0,  1, 3'b111, 0, 0, 0, 0);
    add(1,  0, 0,  0, 3'b111, 0, 1, 0, 0);
    add(6,  0, 0,  0, 3'b111, 0, 1, 0, 0);
    add(2,  0, 1,  0, 3'b111, 0, 1, 0, 0);
    add(1,  0, 1,  0, 3'b111, 0, 2, 0, 0);
    add(7,  0, 1,  0, 3'b111, 0, 2, 0, 0);
    add(1,  0, 1,  0, 3'b110, 0, 3, 0, 0);
    add(1,  0, 1,  0, 3'b110, 0, 3, 0, 0);
    add(1,  0, 1,  0, 3'b100, 0, 3, 0, 0);
    add(2,  0, 1,  0, 3'b000, 0, 3, 0, 0);
    add(1,  0, 1,  0, 3'b000, 1, 4, 0, 0);
    add(5,  0, 1,  0, 3'b000, 1, 4, 0, 0);
    // lock loss in RUNNING: visible 3 edges later
    add(2,  0, 0,  0, 3'b000, 1, 4, 0, 0);
    add(1,  0, 0,  1, 3'b111, 0, 0, 1, 0);
    // relock repeats the sequence
    add(3,  0, 1,  1, 3'b111, 0, 0, 1, 0);
    add(1,  0, 1,  0, 3'b111, 0, 1, 1, 0);
    add(1,  0, 1,  0, 3'b111, 0, 2, 1, 0);
    add(8,  0, 1,  0, 3'b110, 0, 3, 1, 0);
    // rst mid-RELEASE after bit0 released
    add(1,  1, 1,  1, 3'b111, 0, 0, 0, 0);
    // glitch in STABILIZE after 5 stable cycles
    add(3,  0, 1,  1, 3'b111, 0, 0, 0, 0);
    add(1,  0, 1,  0, 3'b111, 0, 1, 0, 0);
    add(1,  0, 1,  0, 3'b111, 0, 2, 0, 0);
    add(4,  0, 1,  0, 3'b111, 0, 2, 0, 0);
    add(1,  0, 0,  0, 3'b111, 0, 2, 0, 0);
    add(1,  0, 1,  0, 3'b111, 0, 2, 0, 0);
    add(1,  0, 1,  0, 3'b111, 0, 1, 0, 0);
    add(1,  0, 1,  0, 3'b111, 0, 2, 0, 0);
    add(7,  0, 1,  0, 3'b111, 0, 2, 0, 0);
    add(1,  0, 1,  0, 3'b110, 0, 3, 0, 0);
    add(4,  0, 1,  0, 3'b000, 0, 3, 0, 0);
    add(1,  0, 1,  0, 3'b000, 1, 4, 0, 0);
    // lock timeout
    add(1,  1, 0,  1, 3'b111, 0, 0, 0, 0);
    add(4,  0, 0,  0, 3'b111, 0, 1, 0, 0);
    add(31, 0, 0,  0, 3'b111, 0, 1, 0, 0);
`ifdef CLKSEQ_PLL_RETRY_EN
    add(1,  0, 0,  1, 3'b111, 0, 0, 0, 1);
    add(4,  0, 0,  0, 3'b111, 0, 1, 0, 1);
    add(32, 0, 0,  1, 3'b111, 0, 0, 0, 1);
    add(4,  0, 1,  0, 3'b111, 0, 1, 0, 1);
    add(14, 0, 1,  0, 3'b000, 1, 4, 0, 1);
`else
    add(1,  0, 0,  1, 3'b111, 0, 5, 0, 1);
    add(4,  0, 0,  1, 3'b111, 0, 5, 0, 1);
    add(32, 0, 0,  1, 3'b111, 0, 5, 0, 1);
    add(4,  0, 1,  1, 3'b111, 0, 5, 0, 1);
    add(14, 0, 1,  1, 3'b111, 0, 5, 0, 1);
`endif
    add(1,  1, 0,  1, 3'b111, 0, 0, 0, 0);   // rst clears lock_fail

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Per-cycle trace of a clean bring-up with lock already high.
    first_pll_low = -1;
    rdy_cyc       = -1;
    for (int b = 0; b < 3; b++) rel[b] = -1;
    rst        = 1'b0;
    pll_locked = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (!pll_rst && first_pll_low < 0) first_pll_low = cyc;
      for (int b = 0; b < 3; b++)
        if (!domain_rst[b] && rel[b] < 0) rel[b] = cyc;
      if (all_ready && rdy_cyc < 0) rdy_cyc = cyc;
    end
    check_int("pll_rst_low_edge", first_pll_low, 4);
    check_int("dom0_release_edge", rel[0], 13);
    check_int("dom1_release_edge", rel[1], 15);
    check_int("dom2_release_edge", rel[2], 17);
    check_int("all_ready_edge", rdy_cyc, 18);
    check_int("final_llc", int'(lock_loss_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
